// File: rtl/mem_stage_mc_pkg.sv
// Shared types, constants and address helpers for the multi-cycle data-memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LAT_CNT_W = 4;
  localparam int unsigned BYTE_W    = 8;

  // Word index: drop the byte-lane bits, then wrap modulo the array depth.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input int unsigned data_w,
                                             input int unsigned depth);
    logic [31:0] shifted;
    shifted = (data_w == 32) ? (byte_addr >> 2) : (byte_addr >> 1);
    return shifted & (depth - 1);
  endfunction

endpackage

// File: rtl/mem_stage_mc_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module mem_array
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned LANES = DATA_W / BYTE_W,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [LANES-1:0]  be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (re) q <= mem[idx];
  end

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: valid/ready request, programmable latency, stall and halt drain.
// Optional MEMSTAGE_ALIGN_CHK_EN: misaligned word accesses are suppressed and flagged on err.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  input  logic              halt,
  output logic              halt_done
`ifdef MEMSTAGE_ALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned LANES  = DATA_W / BYTE_W;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  state_e                 state;
  logic [LAT_CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   req_byte;
  logic                   req_write;
  logic                   rd_loaded;
  logic                   rd_byte;
  logic [LANE_W-1:0]      rd_lane;

  logic                   op;
  logic                   accept;
  logic                   enter_resp;
  logic [ADDR_W-1:0]      eff_addr;
  logic [DATA_W-1:0]      eff_wdata;
  logic                   eff_byte;
  logic                   eff_write;
  logic [LANE_W-1:0]      lane;
  logic                   misalign;
  logic                   ram_we;
  logic                   ram_re;
  logic [LANES-1:0]       ram_be;
  logic [IDX_W-1:0]       ram_idx;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_q;
  logic [DATA_W-1:0]      lane_q;

  assign op         = req_valid & (mem_read | mem_write);
  assign req_ready  = (state == IDLE) & ~halt & ~halt_done;
  assign accept     = op & req_ready;
  assign rsp_valid  = (state == RESP);
  assign stall      = op & ~rsp_valid;
  assign enter_resp = (accept & (LATENCY == 1)) | ((state == BUSY) & (cnt == LAT_CNT_W'(1)));

  // With LATENCY==1 the commit edge is the accept edge, so the live request feeds the array.
  assign eff_addr  = (state == IDLE) ? addr      : req_addr;
  assign eff_wdata = (state == IDLE) ? wdata     : req_wdata;
  assign eff_byte  = (state == IDLE) ? byte_mode : req_byte;
  assign eff_write = (state == IDLE) ? mem_write : req_write;
  assign lane      = eff_addr[LANE_W-1:0];

`ifdef MEMSTAGE_ALIGN_CHK_EN
  assign misalign = ~eff_byte & (lane != '0);
`else
  assign misalign = 1'b0;
`endif

  assign ram_we    = enter_resp & eff_write & ~misalign;
  assign ram_re    = enter_resp & ~eff_write & ~misalign;
  assign ram_idx   = IDX_W'(word_index(32'(eff_addr), DATA_W, DEPTH));
  assign ram_wdata = eff_byte ? {LANES{eff_wdata[BYTE_W-1:0]}} : eff_wdata;

  always_comb begin
    ram_be = '1;
    if (eff_byte) begin
      ram_be       = '0;
      ram_be[lane] = 1'b1;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // The RAM output register is unreset; rd_loaded gives rdata its reset value of zero.
  assign lane_q = ram_q >> {rd_lane, 3'b000};

  always_comb begin
    rdata = '0;
    if (rd_loaded) begin
      if (rd_byte) rdata[BYTE_W-1:0] = lane_q[BYTE_W-1:0];
      else         rdata             = ram_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_byte  <= 1'b0;
      req_write <= 1'b0;
      halt_done <= 1'b0;
      rd_loaded <= 1'b0;
      rd_byte   <= 1'b0;
      rd_lane   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_byte  <= byte_mode;
            req_write <= mem_write;
            cnt       <= LAT_CNT_W'(LATENCY - 1);
            state     <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - LAT_CNT_W'(1);
          if (cnt == LAT_CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if ((state == IDLE) && halt) halt_done <= 1'b1;

      if (ram_re) begin
        rd_loaded <= 1'b1;
        rd_byte   <= eff_byte;
        rd_lane   <= lane;
      end
    end
  end

`ifdef MEMSTAGE_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= enter_resp & misalign;
  end
`endif

endmodule
